// File: rtl/oled_pkg.sv
// Shared constants and types for the PmodOLEDrgb SPI stream decoder.
package oled_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;
  localparam int OLED_PIXELS = OLED_WIDTH * OLED_HEIGHT;

  localparam logic [7:0] CMD_SET_COL = 8'h15;
  localparam logic [7:0] CMD_SET_ROW = 8'h75;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Column/row window commands restart the linear pixel address.
  function automatic logic is_addr_cmd(input logic [7:0] value);
    return (value == CMD_SET_COL) || (value == CMD_SET_ROW);
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-stage synchroniser for the four SPI pins with per-line idle reset
// levels, plus rising-edge detection on sclk and cs.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic cs,
  input  logic sdin,
  input  logic sclk,
  input  logic d_cn,
  output logic cs_sync,
  output logic sdin_sync,
  output logic d_cn_sync,
  output logic sclk_rise,
  output logic cs_rise
);

  // Bit order {d_cn, sclk, sdin, cs}; cs and sclk reset to their idle-high level.
  localparam logic [3:0] RESET_LEVEL = 4'b0101;

  logic [3:0] pin_bus;
  logic [3:0] sync_bus;
  logic       sclk_prev;
  logic       cs_prev;

  assign pin_bus = {d_cn, sclk, sdin, cs};

  for (genvar i = 0; i < 4; i++) begin : g_line
    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        chain <= {SYNC_STAGES{RESET_LEVEL[i]}};
      end else begin
        chain <= {chain[SYNC_STAGES-2:0], pin_bus[i]};
      end
    end

    assign sync_bus[i] = chain[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_prev <= 1'b1;
      cs_prev   <= 1'b1;
    end else begin
      sclk_prev <= sync_bus[2];
      cs_prev   <= sync_bus[0];
    end
  end

  assign cs_sync   = sync_bus[0];
  assign sdin_sync = sync_bus[1];
  assign d_cn_sync = sync_bus[3];
  assign sclk_rise = sync_bus[2] & ~sclk_prev;
  assign cs_rise   = sync_bus[0] & ~cs_prev;

endmodule

// File: rtl/oled_spi_receiver.sv
// Rebuilds command bytes and indexed RGB565 pixel words from the OLED SPI stream.
// Define OLED_RX_ERR_CNT_EN to add the saturating err_count output.
module oled_spi_receiver
  import oled_pkg::*;
#(
  parameter int WIDTH       = OLED_WIDTH,
  parameter int HEIGHT      = OLED_HEIGHT,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        sdin,
  input  logic        sclk,
  input  logic        d_cn,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        pixel_valid,
  output logic [15:0] pixel_data,
  output logic [12:0] pixel_index,
  output logic        byte_abort
`ifdef OLED_RX_ERR_CNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam int          PIXELS     = WIDTH * HEIGHT;
  localparam logic [12:0] LAST_INDEX = 13'(PIXELS - 1);

  logic        cs_sync;
  logic        sdin_sync;
  logic        d_cn_sync;
  logic        sclk_rise;
  logic        cs_rise;

  logic [6:0]  shift_reg;
  logic [2:0]  bit_cnt;
  logic        pair_phase;
  logic [7:0]  high_byte;
  logic [12:0] index_cnt;
  rgb565_t     pixel_word;

  logic        shift_en;
  logic        byte_done;
  logic        cmd_done;
  logic        data_done;
  logic        abort_now;
  logic [7:0]  rx_byte;
  logic [2:0]  bit_cnt_shifted;
  logic [12:0] index_next;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .sdin      (sdin),
    .sclk      (sclk),
    .d_cn      (d_cn),
    .cs_sync   (cs_sync),
    .sdin_sync (sdin_sync),
    .d_cn_sync (d_cn_sync),
    .sclk_rise (sclk_rise),
    .cs_rise   (cs_rise)
  );

  // An edge coinciding with cs rising still belongs to the frame being closed.
  assign shift_en        = sclk_rise & (~cs_sync | cs_rise);
  assign byte_done       = shift_en & (bit_cnt == 3'd7);
  assign cmd_done        = byte_done & ~d_cn_sync;
  assign data_done       = byte_done & d_cn_sync;
  assign rx_byte         = {shift_reg, sdin_sync};
  assign bit_cnt_shifted = shift_en ? bit_cnt + 3'd1 : bit_cnt;
  assign abort_now       = cs_rise & (bit_cnt_shifted != 3'd0);
  assign index_next      = (index_cnt == LAST_INDEX) ? 13'd0 : index_cnt + 13'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      if (shift_en) begin
        shift_reg <= rx_byte[6:0];
      end
      bit_cnt <= abort_now ? 3'd0 : bit_cnt_shifted;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_valid   <= 1'b0;
      pixel_valid <= 1'b0;
      byte_abort  <= 1'b0;
    end else begin
      cmd_valid   <= cmd_done;
      pixel_valid <= data_done & pair_phase;
      byte_abort  <= abort_now;
    end
  end

  // Pair phase and index survive cs pauses; only commands and reset disturb them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pair_phase  <= 1'b0;
      high_byte   <= '0;
      index_cnt   <= '0;
      cmd_byte    <= '0;
      pixel_word  <= '0;
      pixel_index <= '0;
    end else if (cmd_done) begin
      cmd_byte   <= rx_byte;
      pair_phase <= 1'b0;
      if (is_addr_cmd(rx_byte)) begin
        index_cnt <= '0;
      end
    end else if (data_done) begin
      if (!pair_phase) begin
        high_byte  <= rx_byte;
        pair_phase <= 1'b1;
      end else begin
        pixel_word  <= rgb565_t'({high_byte, rx_byte});
        pixel_index <= index_cnt;
        index_cnt   <= index_next;
        pair_phase  <= 1'b0;
      end
    end
  end

  assign pixel_data = pixel_word;

`ifdef OLED_RX_ERR_CNT_EN
  // Counts aborted bytes and commands that orphan a pending high byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if ((abort_now || (cmd_done && pair_phase)) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
